// File: rtl/mini_src_ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes,
// sequencer states, strobe bit positions and opcode classification.
package mini_src_ctrl_pkg;

  localparam int OP_W  = 5;
  localparam int ALU_W = 5;
  localparam int DRV_W = 10;
  localparam int LD_W  = 12;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;

  // drv bit positions (bus drivers, at most one hot)
  localparam int D_PCOUT     = 0;
  localparam int D_ZHIGHOUT  = 1;
  localparam int D_ZLOWOUT   = 2;
  localparam int D_MDROUT    = 3;
  localparam int D_BAOUT     = 4;
  localparam int D_ROUT      = 5;
  localparam int D_HIOUT     = 6;
  localparam int D_LOOUT     = 7;
  localparam int D_INPORTOUT = 8;
  localparam int D_COUT      = 9;

  // ld bit positions (register loads)
  localparam int L_PCIN      = 0;
  localparam int L_MARIN     = 1;
  localparam int L_MDRIN     = 2;
  localparam int L_IRIN      = 3;
  localparam int L_YIN       = 4;
  localparam int L_RIN       = 5;
  localparam int L_HIIN      = 6;
  localparam int L_LOIN      = 7;
  localparam int L_ZHIGHIN   = 8;
  localparam int L_ZLOWIN    = 9;
  localparam int L_CONIN     = 10;
  localparam int L_OUTPORTIN = 11;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT, STOPPED
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } op_class_e;

  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    op_class_e c;
    case (op)
      OP_LD:                          c = C_LD;
      OP_LDI:                         c = C_LDI;
      OP_ST:                          c = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  c = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:       c = C_IMM;
      OP_MFHI:                        c = C_MFHI;
      OP_MFLO:                        c = C_MFLO;
      OP_NOP:                         c = C_NOP;
      OP_HALT:                        c = C_HALT;
      default:                        c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe decode for the Mini-SRC control unit: maps the current
// sequencer step and opcode to every datapath control output.
module cu_decode
  import mini_src_ctrl_pkg::*;
(
  input  state_e             state_i,
  input  logic [OP_W-1:0]    opcode_i,
  output logic [DRV_W-1:0]   drv_o,
  output logic [LD_W-1:0]    ld_o,
  output logic               inc_pc_o,
  output logic               read_o,
  output logic               write_o,
  output logic               gra_o,
  output logic               grb_o,
  output logic               grc_o,
  output logic [ALU_W-1:0]   alu_op_o,
  output logic               illegal_o
);

  op_class_e cls;

  assign cls = op_class(opcode_i);

  always_comb begin
    drv_o     = '0;
    ld_o      = '0;
    inc_pc_o  = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    gra_o     = 1'b0;
    grb_o     = 1'b0;
    grc_o     = 1'b0;
    alu_op_o  = '0;
    illegal_o = 1'b0;
    case (state_i)
      T0: begin
        drv_o[D_PCOUT] = 1'b1;
        ld_o[L_MARIN]  = 1'b1;
        ld_o[L_PCIN]   = 1'b1;
        inc_pc_o       = 1'b1;
      end
      T1: begin
        read_o        = 1'b1;
        ld_o[L_MDRIN] = 1'b1;
      end
      T2: begin
        drv_o[D_MDROUT] = 1'b1;
        ld_o[L_IRIN]    = 1'b1;
      end
      T3: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            grb_o          = 1'b1;
            drv_o[D_BAOUT] = 1'b1;
            ld_o[L_YIN]    = 1'b1;
          end
          C_ALU, C_IMM: begin
            grb_o         = 1'b1;
            drv_o[D_ROUT] = 1'b1;
            ld_o[L_YIN]   = 1'b1;
          end
          C_MFHI: begin
            drv_o[D_HIOUT] = 1'b1;
            gra_o          = 1'b1;
            ld_o[L_RIN]    = 1'b1;
          end
          C_MFLO: begin
            drv_o[D_LOOUT] = 1'b1;
            gra_o          = 1'b1;
            ld_o[L_RIN]    = 1'b1;
          end
          C_ILL:   illegal_o = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            drv_o[D_COUT]  = 1'b1;
            ld_o[L_ZLOWIN] = 1'b1;
            alu_op_o       = ALU_ADD;
          end
          C_ALU: begin
            grc_o          = 1'b1;
            drv_o[D_ROUT]  = 1'b1;
            ld_o[L_ZLOWIN] = 1'b1;
            alu_op_o       = opcode_i;
          end
          C_IMM: begin
            drv_o[D_COUT]  = 1'b1;
            ld_o[L_ZLOWIN] = 1'b1;
            alu_op_o       = opcode_i;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_LDI, C_ALU, C_IMM: begin
            drv_o[D_ZLOWOUT] = 1'b1;
            gra_o            = 1'b1;
            ld_o[L_RIN]      = 1'b1;
          end
          C_LD, C_ST: begin
            drv_o[D_ZLOWOUT] = 1'b1;
            ld_o[L_MARIN]    = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          C_LD: begin
            read_o        = 1'b1;
            ld_o[L_MDRIN] = 1'b1;
          end
          // store data goes register -> MDR with no memory read
          C_ST: begin
            gra_o         = 1'b1;
            drv_o[D_ROUT] = 1'b1;
            ld_o[L_MDRIN] = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          C_LD: begin
            drv_o[D_MDROUT] = 1'b1;
            gra_o           = 1'b1;
            ld_o[L_RIN]     = 1'b1;
          end
          C_ST:    write_o = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Mini-SRC hardwired control unit: step register, next-step logic and Stop
// handling. Define MEM_WAIT_EN to stretch memory steps until mem_ready.
//
// state   | meaning
// RST     | held in reset, all strobes low
// T0..T2  | instruction fetch
// T3..T7  | execute steps, length depends on opcode
// HALT    | halt executed, left only by reset
// STOPPED | Stop seen at a fetch boundary, resumes when Stop drops
module control_sequencer
  import mini_src_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             Stop,
  input  logic             mem_ready,
  output logic [9:0]       drv,
  output logic [11:0]      ld,
  output logic             IncPC,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic [ALUW-1:0]  alu_op,
  output logic             Run,
  output logic             illegal
);

  state_e          state_q, state_d;
  state_e          next_fetch;
  op_class_e       cls;
  logic [OPW-1:0]  opcode;
  logic            mem_ok;
  logic            unused_ir;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];
  assign cls       = op_class(opcode);

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    next_fetch = Stop ? STOPPED : T0;
    case (state_q)
      RST:     state_d = T0;
      T0:      state_d = T1;
      T1:      state_d = mem_ok ? T2 : T1;
      // IR is being loaded during T2, so a nop is recognised from the IR input
      T2:      state_d = (cls == C_NOP) ? next_fetch : T3;
      T3: begin
        case (cls)
          C_HALT:                       state_d = HALT;
          C_MFHI, C_MFLO, C_ILL, C_NOP: state_d = next_fetch;
          default:                      state_d = T4;
        endcase
      end
      T4:      state_d = T5;
      T5:      state_d = (cls == C_LD || cls == C_ST) ? T6 : next_fetch;
      T6:      state_d = (cls == C_LD && !mem_ok) ? T6 : T7;
      T7:      state_d = (cls == C_ST && !mem_ok) ? T7 : next_fetch;
      HALT:    state_d = HALT;
      STOPPED: state_d = Stop ? STOPPED : T0;
      default: state_d = RST;
    endcase
  end

  assign Run = (state_q inside {T0, T1, T2, T3, T4, T5, T6, T7});

  cu_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .drv_o     (drv),
    .ld_o      (ld),
    .inc_pc_o  (IncPC),
    .read_o    (Read),
    .write_o   (Write),
    .gra_o     (Gra),
    .grb_o     (Grb),
    .grc_o     (Grc),
    .alu_op_o  (alu_op),
    .illegal_o (illegal)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle strobe vectors are
// queued per instruction and compared every falling edge.
module tb_control_sequencer;

  typedef struct packed {
    logic        run;
    logic        ill;
    logic [9:0]  drv;
    logic [11:0] ld;
    logic [5:0]  flg;   // IncPC, Read, Write, Gra, Grb, Grc
    logic [4:0]  alu;
  } vec_t;

  localparam logic [9:0] D_PC = 10'd1 << 0, D_ZLO = 10'd1 << 2, D_MDR = 10'd1 << 3,
                         D_BA = 10'd1 << 4, D_R   = 10'd1 << 5, D_HI  = 10'd1 << 6,
                         D_LO = 10'd1 << 7, D_C   = 10'd1 << 9;
  localparam logic [11:0] L_PC = 12'd1 << 0, L_MAR = 12'd1 << 1, L_MDR = 12'd1 << 2,
                          L_IR = 12'd1 << 3, L_Y   = 12'd1 << 4, L_R   = 12'd1 << 5,
                          L_ZLO = 12'd1 << 9;
  localparam logic [5:0] F_INC = 6'b100000, F_RD = 6'b010000, F_WR = 6'b001000,
                         F_GA  = 6'b000100, F_GB = 6'b000010, F_GC = 6'b000001;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Stop;
  logic        mem_ready;
  logic [9:0]  drv;
  logic [11:0] ld;
  logic        IncPC, Read, Write, Gra, Grb, Grc, Run, illegal;
  logic [4:0]  alu_op;

  int   n_chk = 0;
  int   n_bad = 0;
  vec_t exp_q[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .Stop(Stop), .mem_ready(mem_ready),
    .drv(drv), .ld(ld), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .alu_op(alu_op), .Run(Run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic vec_t obs_vec();
    vec_t o;
    o.run = Run;
    o.ill = illegal;
    o.drv = drv;
    o.ld  = ld;
    o.flg = {IncPC, Read, Write, Gra, Grb, Grc};
    o.alu = alu_op;
    return o;
  endfunction

  function automatic vec_t v(input logic [9:0] d, input logic [11:0] l,
                             input logic [5:0] f, input logic [4:0] a);
    vec_t e;
    e.run = 1'b1;
    e.ill = 1'b0;
    e.drv = d;
    e.ld  = l;
    e.flg = f;
    e.alu = a;
    return e;
  endfunction

  function automatic vec_t zero_vec();
    return '0;
  endfunction

  task automatic push_instr(input logic [4:0] op);
    vec_t ill_v;
    int   wr_cycles;
    exp_q.push_back(v(D_PC, L_PC | L_MAR, F_INC, 5'd0));
    exp_q.push_back(v('0, L_MDR, F_RD, 5'd0));
    exp_q.push_back(v(D_MDR, L_IR, '0, 5'd0));
    case (op)
      5'b00001: begin
        exp_q.push_back(v(D_BA, L_Y, F_GB, 5'd0));
        exp_q.push_back(v(D_C, L_ZLO, '0, 5'b00011));
        exp_q.push_back(v(D_ZLO, L_R, F_GA, 5'd0));
      end
      5'b00000, 5'b00010: begin
        exp_q.push_back(v(D_BA, L_Y, F_GB, 5'd0));
        exp_q.push_back(v(D_C, L_ZLO, '0, 5'b00011));
        exp_q.push_back(v(D_ZLO, L_MAR, '0, 5'd0));
        if (op == 5'b00000) begin
          exp_q.push_back(v('0, L_MDR, F_RD, 5'd0));
          exp_q.push_back(v(D_MDR, L_R, F_GA, 5'd0));
        end else begin
          exp_q.push_back(v(D_R, L_MDR, F_GA, 5'd0));
`ifdef MEM_WAIT_EN
          wr_cycles = 4;
`else
          wr_cycles = 1;
`endif
          for (int i = 0; i < wr_cycles; i++) exp_q.push_back(v('0, '0, F_WR, 5'd0));
        end
      end
      5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
        exp_q.push_back(v(D_R, L_Y, F_GB, 5'd0));
        exp_q.push_back(v(D_R, L_ZLO, F_GC, op));
        exp_q.push_back(v(D_ZLO, L_R, F_GA, 5'd0));
      end
      5'b01011, 5'b01100, 5'b01101: begin
        exp_q.push_back(v(D_R, L_Y, F_GB, 5'd0));
        exp_q.push_back(v(D_C, L_ZLO, '0, op));
        exp_q.push_back(v(D_ZLO, L_R, F_GA, 5'd0));
      end
      5'b10111: exp_q.push_back(v(D_HI, L_R, F_GA, 5'd0));
      5'b11000: exp_q.push_back(v(D_LO, L_R, F_GA, 5'd0));
      5'b11001: ;
      5'b11010: exp_q.push_back(v('0, '0, '0, 5'd0));
      default: begin
        ill_v     = v('0, '0, '0, 5'd0);
        ill_v.ill = 1'b1;
        exp_q.push_back(ill_v);
      end
    endcase
  endtask

  task automatic cycle_chk(input string tag);
    vec_t e;
    @(negedge clock);
    if (exp_q.size() == 0) begin
      check_val({tag, "_q_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 64'(obs_vec()), 64'(e));
    end
  endtask

  // Runs one instruction; the k-indexed hooks act right after sample k.
  task automatic run_instr(input string name, input logic [31:0] ir, input int n_zero,
                           input int stop_set, input int stop_clr,
                           input int mr_lo, input int mr_hi);
    int k;
    push_instr(ir[31:27]);
    for (int i = 0; i < n_zero; i++) exp_q.push_back(zero_vec());
    k = 0;
    while (exp_q.size() > 0) begin
      cycle_chk($sformatf("%s_k%0d", name, k));
      if (k == 0)        IR = ir;
      if (k == stop_set) Stop = 1'b1;
      if (k == stop_clr) Stop = 1'b0;
      if (k == mr_lo)    mem_ready = 1'b0;
      if (k == mr_hi)    mem_ready = 1'b1;
      k++;
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    clear     = 1'b0;
    IR        = 32'h0;
    Stop      = 1'b0;
    mem_ready = 1'b1;

    exp_q.push_back(zero_vec());
    exp_q.push_back(zero_vec());
    cycle_chk("reset0");
    cycle_chk("reset1");
    clear = 1'b1;

    run_instr("ldi",   32'h09800065, 0, -1, -1, -1, -1);
    run_instr("add",   32'h1A920000, 0, -1, -1, -1, -1);
    run_instr("sub",   32'h21920000, 0, -1, -1, -1, -1);
    run_instr("addi",  32'h59900010, 0, -1, -1, -1, -1);
    run_instr("ori",   32'h69900010, 0, -1, -1, -1, -1);
    run_instr("mfhi",  32'hB8800000, 0, -1, -1, -1, -1);
    run_instr("mflo",  32'hC0800000, 0, -1, -1, -1, -1);
    run_instr("nop",   32'hC8000000, 0, -1, -1, -1, -1);
    run_instr("ill",   32'hF8000000, 0, -1, -1, -1, -1);
    run_instr("ld_stop", 32'h01000004, 3, 5, 10, -1, -1);
    run_instr("st_wait", 32'h11000008, 0, -1, -1, 6, 9);

    // reset asserted while the add is in T4
    push_instr(5'b00011);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    for (int k = 0; k < 5; k++) begin
      cycle_chk($sformatf("add_abort_k%0d", k));
      if (k == 0) IR = 32'h1A920000;
    end
    #2 clear = 1'b0;
    #1 check_val("rst_mid_t4", 64'(obs_vec()), 64'(zero_vec()));
    exp_q.push_back(zero_vec());
    cycle_chk("rst_hold");
    clear = 1'b1;
    run_instr("ldi_after_rst", 32'h09800065, 0, -1, -1, -1, -1);

    run_instr("halt", 32'hD0000000, 20, 0, 12, -1, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
